// File: rtl/morse_decoder.sv
// Serial Morse decoder: one symbol per cycle in, one ASCII character per
// terminating gap out, with a strobe for malformed input.
module morse_decoder (
  input  logic       clock,
  input  logic       Clr,
  input  logic       Dot,
  input  logic       Dash,
  input  logic       Lg,
  input  logic       Wg,
  input  logic       Valid,
  output logic [7:0] Dout,
  output logic       Dvalid,
  output logic       Error
);

  logic [2:0] len_q, len_d;
  logic [5:0] pat_q, pat_d;
  logic [7:0] dout_q, dout_d;
  logic       dvalid_q, dvalid_d;
  logic       error_q, error_d;
  logic [2:0] nsym;
  logic [8:0] hit;

  // Returns {hit, ascii}; pat holds the code right-aligned, first symbol MSB.
  function automatic logic [8:0] lookup(input logic [2:0] l,
                                        input logic [5:0] p);
    logic [8:0] r;
    r = '0;
    case ({l, p})
      {3'd2, 6'b000001}: r = {1'b1, 8'h41};
      {3'd4, 6'b001000}: r = {1'b1, 8'h42};
      {3'd4, 6'b001010}: r = {1'b1, 8'h43};
      {3'd3, 6'b000100}: r = {1'b1, 8'h44};
      {3'd1, 6'b000000}: r = {1'b1, 8'h45};
      {3'd4, 6'b000010}: r = {1'b1, 8'h46};
      {3'd3, 6'b000110}: r = {1'b1, 8'h47};
      {3'd4, 6'b000000}: r = {1'b1, 8'h48};
      {3'd2, 6'b000000}: r = {1'b1, 8'h49};
      {3'd4, 6'b000111}: r = {1'b1, 8'h4A};
      {3'd3, 6'b000101}: r = {1'b1, 8'h4B};
      {3'd4, 6'b000100}: r = {1'b1, 8'h4C};
      {3'd2, 6'b000011}: r = {1'b1, 8'h4D};
      {3'd2, 6'b000010}: r = {1'b1, 8'h4E};
      {3'd3, 6'b000111}: r = {1'b1, 8'h4F};
      {3'd4, 6'b000110}: r = {1'b1, 8'h50};
      {3'd4, 6'b001101}: r = {1'b1, 8'h51};
      {3'd3, 6'b000010}: r = {1'b1, 8'h52};
      {3'd3, 6'b000000}: r = {1'b1, 8'h53};
      {3'd1, 6'b000001}: r = {1'b1, 8'h54};
      {3'd3, 6'b000001}: r = {1'b1, 8'h55};
      {3'd4, 6'b000001}: r = {1'b1, 8'h56};
      {3'd3, 6'b000011}: r = {1'b1, 8'h57};
      {3'd4, 6'b001001}: r = {1'b1, 8'h58};
      {3'd4, 6'b001011}: r = {1'b1, 8'h59};
      {3'd4, 6'b001100}: r = {1'b1, 8'h5A};
      {3'd5, 6'b011111}: r = {1'b1, 8'h30};
      {3'd5, 6'b001111}: r = {1'b1, 8'h31};
      {3'd5, 6'b000111}: r = {1'b1, 8'h32};
      {3'd5, 6'b000011}: r = {1'b1, 8'h33};
      {3'd5, 6'b000001}: r = {1'b1, 8'h34};
      {3'd5, 6'b000000}: r = {1'b1, 8'h35};
      {3'd5, 6'b010000}: r = {1'b1, 8'h36};
      {3'd5, 6'b011000}: r = {1'b1, 8'h37};
      {3'd5, 6'b011100}: r = {1'b1, 8'h38};
      {3'd5, 6'b011110}: r = {1'b1, 8'h39};
      {3'd6, 6'b010101}: r = {1'b1, 8'h2E};
      {3'd6, 6'b110011}: r = {1'b1, 8'h2C};
      {3'd6, 6'b001100}: r = {1'b1, 8'h3F};
      {3'd5, 6'b010010}: r = {1'b1, 8'h2F};
      default:           r = '0;
    endcase
    return r;
  endfunction

  assign nsym = 3'(Dot) + 3'(Dash) + 3'(Lg) + 3'(Wg);
  assign hit  = lookup(len_q, pat_q);

  always_comb begin
    len_d    = len_q;
    pat_d    = pat_q;
    dout_d   = dout_q;
    dvalid_d = 1'b0;
    error_d  = 1'b0;
    if (Valid) begin
      if (nsym > 3'd1) begin
        error_d = 1'b1;
        len_d   = '0;
        pat_d   = '0;
      end else if (Dot || Dash) begin
        if (len_q == 3'd6) begin
          error_d = 1'b1;
          len_d   = '0;
          pat_d   = '0;
        end else begin
          pat_d = {pat_q[4:0], Dash};
          len_d = len_q + 3'd1;
        end
      end else if (Lg) begin
        if (len_q != 3'd0) begin
          if (hit[8]) begin
            dout_d   = hit[7:0];
            dvalid_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
          len_d = '0;
          pat_d = '0;
        end
      end else if (Wg) begin
        // A word gap with a letter still pending is flagged but still spaces.
        dout_d   = 8'h20;
        dvalid_d = 1'b1;
        error_d  = (len_q != 3'd0);
        len_d    = '0;
        pat_d    = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (Clr) begin
      len_q    <= '0;
      pat_q    <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      len_q    <= len_d;
      pat_q    <= pat_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      error_q  <= error_d;
    end
  end

  assign Dout   = dout_q;
  assign Dvalid = dvalid_q;
  assign Error  = error_q;

endmodule

// File: tb/tb_morse_decoder.sv
// Bench for morse_decoder: directed scenarios plus random symbol streams,
// checked every cycle against a string-keyed Morse dictionary model.
module tb_morse_decoder;

  logic       clock = 1'b0;
  logic       Clr = 1'b1;
  logic       Dot = 1'b0;
  logic       Dash = 1'b0;
  logic       Lg = 1'b0;
  logic       Wg = 1'b0;
  logic       Valid = 1'b0;
  logic [7:0] Dout;
  logic       Dvalid;
  logic       Error;

  morse_decoder dut (
    .clock (clock),
    .Clr   (Clr),
    .Dot   (Dot),
    .Dash  (Dash),
    .Lg    (Lg),
    .Wg    (Wg),
    .Valid (Valid),
    .Dout  (Dout),
    .Dvalid(Dvalid),
    .Error (Error)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail = 0;
  int n_dv = 0;
  int n_err = 0;
  string txt = "";

  string codes[40] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
    ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
    "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
    "-----", ".----", "..---", "...--", "....-", ".....", "-....",
    "--...", "---..", "----.", ".-.-.-", "--..--", "..--..", "-..-."
  };
  string chars = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789.,?/";
  byte tbl[string];

  string      m_pend = "";
  logic [7:0] m_dout = 8'h00;
  logic       m_dv = 1'b0;
  logic       m_er = 1'b0;

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: pending code kept as a dot/dash string.
  task automatic model(input logic c, d, s, l, w, v);
    int n;
    m_dv = 1'b0;
    m_er = 1'b0;
    if (c) begin
      m_pend = "";
      m_dout = 8'h00;
    end else if (v) begin
      n = int'(d) + int'(s) + int'(l) + int'(w);
      if (n > 1) begin
        m_er = 1'b1;
        m_pend = "";
      end else if (d || s) begin
        if (m_pend.len() == 6) begin
          m_er = 1'b1;
          m_pend = "";
        end else begin
          m_pend = {m_pend, d ? "." : "-"};
        end
      end else if (l && m_pend.len() > 0) begin
        if (tbl.exists(m_pend)) begin
          m_dout = tbl[m_pend];
          m_dv = 1'b1;
        end else begin
          m_er = 1'b1;
        end
        m_pend = "";
      end else if (w) begin
        m_dout = 8'h20;
        m_dv = 1'b1;
        m_er = (m_pend.len() > 0);
        m_pend = "";
      end
    end
  endtask

  task automatic step(input logic c, d, s, l, w, v);
    @(negedge clock);
    Clr = c;
    Dot = d;
    Dash = s;
    Lg = l;
    Wg = w;
    Valid = v;
    @(posedge clock);
    model(c, d, s, l, w, v);
    #1;
    check("dout", Dout, m_dout);
    check("dvalid", 8'(Dvalid), 8'(m_dv));
    check("error", 8'(Error), 8'(m_er));
    if (Dvalid) begin
      n_dv++;
      txt = {txt, $sformatf("%c", Dout)};
    end
    if (Error) n_err++;
  endtask

  // '.' dot, '-' dash, ' ' letter gap, '/' word gap
  task automatic send(input string str);
    for (int i = 0; i < str.len(); i++) begin
      case (str[i])
        "."     : step(0, 1, 0, 0, 0, 1);
        "-"     : step(0, 0, 1, 0, 0, 1);
        " "     : step(0, 0, 0, 1, 0, 1);
        default : step(0, 0, 0, 0, 1, 1);
      endcase
    end
  endtask

  initial begin
    logic [7:0] prev;
    int r;
    for (int i = 0; i < 40; i++) tbl[codes[i]] = chars[i];

    step(1, 0, 0, 0, 0, 0);
    check("rst_dout", Dout, 8'h00);
    check("rst_dvalid", 8'(Dvalid), 8'h00);
    check("rst_error", 8'(Error), 8'h00);

    n_dv = 0; n_err = 0; txt = "";
    send("-- --- .-. ... . /-.-. --- -.. . ");
    n_assert++;
    assert (txt == "MORSE CODE") else begin
      n_fail++;
      $error("FAIL morse_text observed=%s expected=MORSE CODE", txt);
    end
    check("morse_dv_count", 8'(n_dv), 8'd10);
    check("morse_err_count", 8'(n_err), 8'd0);

    n_dv = 0;
    send("-.");
    step(1, 0, 0, 0, 0, 1);
    send(". ");
    check("clr_e_dout", Dout, 8'h45);
    check("clr_dv_count", 8'(n_dv), 8'd1);

    n_dv = 0;
    send("......");
    step(0, 1, 0, 0, 0, 1);
    check("dot7_error", 8'(Error), 8'h01);
    send(" ");
    check("dot7_lg_dv", 8'(Dvalid), 8'h00);
    check("dot7_dout", Dout, 8'h45);
    check("dot7_dv_count", 8'(n_dv), 8'd0);

    send("..-- ");
    check("miss_error", 8'(Error), 8'h01);
    check("miss_dv", 8'(Dvalid), 8'h00);
    send(".- ");
    check("a_dout", Dout, 8'h41);

    repeat (3) step(0, 1, 0, 0, 0, 0);
    send("- ");
    check("masked_t_dout", Dout, 8'h54);

    step(0, 1, 1, 0, 0, 1);
    check("multi_error", 8'(Error), 8'h01);
    send(".-/");
    check("wg_dout", Dout, 8'h20);
    check("wg_dvalid", 8'(Dvalid), 8'h01);
    check("wg_error", 8'(Error), 8'h01);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) send("/");
      else send({codes[$urandom_range(0, 39)], " "});
    end

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      prev = 8'($urandom_range(0, 9) != 0);
      if (r < 38)      step(0, 1, 0, 0, 0, prev[0]);
      else if (r < 72) step(0, 0, 1, 0, 0, prev[0]);
      else if (r < 86) step(0, 0, 0, 1, 0, prev[0]);
      else if (r < 91) step(0, 0, 0, 0, 1, prev[0]);
      else if (r < 95) step(0, 1'($urandom), 1'($urandom),
                            1, 1'($urandom), prev[0]);
      else if (r < 99) step(0, 0, 0, 0, 0, prev[0]);
      else             step(1, 1'($urandom), 1'($urandom), 0, 0, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/morse_decoder.md
# morse_decoder

Serial Morse-code decoder. Each clock cycle it samples one symbol (dot, dash, letter gap or word gap), accumulates dots and dashes into a pending code, and emits the 8-bit ASCII character when a gap closes the code. It sits between a symbol source (key/timing front end) and a character consumer, which sees a one-cycle `Dvalid` strobe per character and a one-cycle `Error` strobe per malformed input.

## Interface
- No parameters. Maximum code length is fixed at 6 symbols.
- `clock`  in  1  system clock; all state updates on rising edge.
- `Clr`  in  1  reset; synchronous, active-high.
- `Dot`  in  1  current symbol is a dot.
- `Dash`  in  1  current symbol is a dash.
- `Lg`  in  1  letter gap; terminates the pending code.
- `Wg`  in  1  word gap; emits a space.
- `Valid`  in  1  symbol-qualify; when low, the cycle is ignored.
- `Dout`  out  8  last decoded ASCII character (registered).
- `Dvalid`  out  1  one-cycle strobe: `Dout` was updated this cycle.
- `Error`  out  1  one-cycle strobe: malformed input detected.

## Operation
- State: 3-bit symbol count `len` (0..6) and 6-bit pattern `pat`. Dot = 0, dash = 1, shifted in LSB-first order of arrival (first symbol is the MSB of the used bits).
- Per rising edge, in priority order:
  - `Clr`=1: `len`=0, `pat`=0, `Dout`=0x00, `Dvalid`=0, `Error`=0.
  - `Valid`=0: state and `Dout` hold; `Dvalid`=0, `Error`=0.
  - More than one of `Dot`/`Dash`/`Lg`/`Wg` high: `Error` pulse; pending code discarded.
  - None high: idle; nothing changes (strobes low).
  - `Dot`/`Dash`:
    - If `len`<6: append the symbol and increment `len`.
    - If `len`=6: `Error` pulse; pending code discarded.
  - `Lg` with `len`=0: ignored, so repeated gaps are legal.
  - `Lg` with `len`>0: look up (`len`,`pat`).
    - Hit: `Dout`=ASCII, `Dvalid` pulse.
    - Miss: `Error` pulse; `Dout` holds.
    - Either way, pending code cleared.
  - `Wg`: `Dout`=0x20, `Dvalid` pulse.
    - If `len`>0, also assert `Error` in the same cycle and discard the pending code. An unterminated letter before a word gap is malformed.
- Lookup table:
  - Letters: A `.-`, B `-...`, C `-.-.`, D `-..`, E `.`, F `..-.`, G `--.`, H `....`, I `..`, J `.---`, K `-.-`, L `.-..`, M `--`, N `-.`, O `---`, P `.--.`, Q `--.-`, R `.-.`, S `...`, T `-`, U `..-`, V `...-`, W `.--`, X `-..-`, Y `-.--`, Z `--..`.
  - Letters decode to uppercase (0x41–0x5A).
  - Digits: 0 `-----`, 1 `.----` … 5 `.....`, 6 `-....` … 9 `----.`.
  - Punctuation: `.` `.-.-.-`, `,` `--..--`, `?` `..--..`, `/` `-..-.`.
  - All other (len,pat) combinations are a miss.

## Timing
- Inputs are sampled on the rising edge and must be stable around it; the source changes them on the falling edge.
- Latency: a terminating `Lg`/`Wg` sampled at edge N produces `Dout`/`Dvalid`/`Error` valid from edge N until edge N+1.
- `Dvalid` and `Error` are never high for two consecutive cycles unless they are caused by consecutive inputs.
- `Dout` holds its value between strobes.
- Reset values: `Dout`=0x00, `Dvalid`=0, `Error`=0, `len`=0.
- `Clr` mid-letter discards the partial code; there is no output for it.
- There is no backpressure: the consumer must accept every `Dvalid` cycle.

## Test plan
- Symbol stream `-- --- .-. ... . /-.-. --- -.. . ` (one per cycle, `Valid`=1):
  - Ten `Dvalid` strobes with `Dout` = "MORSE CODE" (0x4D 4F 52 53 45 20 43 4F 44 45).
  - Each strobe appears one cycle after its gap.
  - `Error` never asserts.
- `Clr` after `-.` then `.` then `Lg` → single `Dvalid` with `Dout`=0x45 ('E'); nothing emitted for the discarded `-.`.
- Seven dots then `Lg` → `Error` on the 7th dot; the following `Lg` is ignored (no strobe); `Dout` unchanged.
- `..--` then `Lg` → `Error` pulse, no `Dvalid`; a subsequent `.-` then `Lg` → `Dout`=0x41.
- `.` with `Valid`=0 for 3 cycles, then `-` and `Lg` with `Valid`=1 → `Dout`=0x54 ('T'); the masked dots are not counted.
- `Dot`=`Dash`=1 in one cycle → `Error`; `Wg` with pending `.-` → `Dout`=0x20, `Dvalid`=1 and `Error`=1 in the same cycle.
